// File: rtl/alu_seq.sv
// Accumulator/carry sequencer driving an external combinational ALU; repeats shift-class ops.
// Optional zero flag output enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_seq #(
  parameter int W     = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_xy,
  input  logic [W-1:0]     cmd_b,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             acc_we,
  input  logic [W-1:0]     acc_wdata,
  input  logic             carry_we,
  input  logic             carry_wdata,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_xy,
  output logic             alu_cin,
  input  logic [W-1:0]     alu_q,
  input  logic             alu_cout,
  output logic [W-1:0]     acc,
  output logic             carry,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             busy,
  output logic             done
);

  // Command handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_valid may be withdrawn at any time before that edge.

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [3:0]         op_r;
  logic               xy_r;
  logic [W-1:0]       b_r;
  logic [CNT_W-1:0]   rem;
  logic               accept;
  logic               last_iter;

  assign last_iter = (rem == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !acc_we && !carry_we;
        accept    = cmd_valid && cmd_ready;
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        if (last_iter) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      carry <= 1'b0;
      op_r  <= '0;
      xy_r  <= 1'b0;
      b_r   <= '0;
      rem   <= '0;
      done  <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (acc_we) begin
          acc <= acc_wdata;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          zero <= (acc_wdata == '0);
`endif
        end
        if (carry_we) carry <= carry_wdata;
        if (accept) begin
          op_r <= cmd_op;
          xy_r <= cmd_xy;
          b_r  <= cmd_b;
          // Only shift-class ops (op[3]=1) iterate; everything else runs once.
          rem  <= cmd_op[3] ? cmd_cnt : '0;
        end
      end else begin
        acc   <= alu_q;
        carry <= alu_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero  <= (alu_q == '0);
`endif
        if (last_iter) done <= 1'b1;
        else           rem  <= rem - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign alu_a   = acc;
  assign alu_b   = b_r;
  assign alu_op  = op_r;
  assign alu_xy  = xy_r;
  assign alu_cin = carry;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a small ALU model closes the loop, vectors plus multi-cycle sequences.
module tb_alu_seq;
  localparam int W     = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic             cmd_xy;
  logic [W-1:0]     cmd_b;
  logic [CNT_W-1:0] cmd_cnt;
  logic             acc_we;
  logic [W-1:0]     acc_wdata;
  logic             carry_we;
  logic             carry_wdata;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [3:0]       alu_op;
  logic             alu_xy;
  logic             alu_cin;
  logic [W-1:0]     alu_q;
  logic             alu_cout;
  logic [W-1:0]     acc;
  logic             carry;
  logic             busy;
  logic             done;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic             zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_xy(cmd_xy),
    .cmd_b(cmd_b), .cmd_cnt(cmd_cnt),
    .acc_we(acc_we), .acc_wdata(acc_wdata), .carry_we(carry_we), .carry_wdata(carry_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_xy(alu_xy), .alu_cin(alu_cin),
    .alu_q(alu_q), .alu_cout(alu_cout),
    .acc(acc), .carry(carry),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .zero(zero),
`endif
    .busy(busy), .done(done)
  );

  // Reference ALU: bitwise / add-sub / shift-left / shift-right selected by op[3:2].
  logic       shift_in;
  logic [W:0] sum;
  always_comb begin
    alu_q    = '0;
    alu_cout = alu_cin;
    sum      = '0;
    case (alu_op[1:0])
      2'b00:   shift_in = 1'b0;
      2'b01:   shift_in = alu_cin;
      2'b10:   shift_in = alu_a[0];
      default: shift_in = alu_a[W-1];
    endcase
    case (alu_op[3:2])
      2'b00: begin
        case (alu_op[1:0])
          2'b00:   alu_q = alu_a & alu_b;
          2'b01:   alu_q = alu_a | alu_b;
          2'b10:   alu_q = alu_a ^ alu_b;
          default: alu_q = ~alu_a;
        endcase
      end
      2'b01: begin
        sum = {1'b0, alu_a} + {1'b0, (alu_xy ? ~alu_b : alu_b)}
            + {{W{1'b0}}, (alu_op[0] ? alu_cin : alu_xy)};
        alu_q    = sum[W-1:0];
        alu_cout = sum[W];
      end
      2'b10: begin
        alu_q    = {alu_a[W-2:0], shift_in};
        alu_cout = alu_a[W-1];
      end
      default: begin
        alu_q    = {shift_in, alu_a[W-1:1]};
        alu_cout = alu_a[0];
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic load(input logic [W-1:0] a, input logic c);
    acc_we = 1'b1; acc_wdata = a; carry_we = 1'b1; carry_wdata = c;
    @(negedge clk);
    acc_we = 1'b0; carry_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic xy, input logic [W-1:0] b,
                       input logic [CNT_W-1:0] cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_xy = xy; cmd_b = b; cmd_cnt = cnt;
    #1 chk("issue_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int iters);
    iters = 0;
    while (busy === 1'b1 && iters < 64) begin
      iters++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [W-1:0]     a0;
    logic             c0;
    logic [3:0]       op;
    logic             xy;
    logic [W-1:0]     b;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     exp_acc;
    logic             exp_c;
    int               exp_iter;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int iters;
    logic [W-1:0] rot_seq[4];

    vecs[0]  = '{8'h7F, 1'b0, 4'b0100, 1'b0, 8'h01, 3'd0, 8'h80, 1'b0, 1};
    vecs[1]  = '{8'hFF, 1'b0, 4'b0100, 1'b0, 8'h01, 3'd0, 8'h00, 1'b1, 1};
    vecs[2]  = '{8'h00, 1'b1, 4'b0101, 1'b0, 8'h00, 3'd0, 8'h01, 1'b0, 1};
    vecs[3]  = '{8'h81, 1'b0, 4'b1011, 1'b0, 8'h00, 3'd3, 8'h18, 1'b0, 4};
    vecs[4]  = '{8'h80, 1'b0, 4'b1111, 1'b0, 8'h00, 3'd7, 8'hFF, 1'b1, 8};
    vecs[5]  = '{8'hF0, 1'b0, 4'b0000, 1'b0, 8'h3C, 3'd0, 8'h30, 1'b0, 1};
    vecs[6]  = '{8'hF0, 1'b1, 4'b0010, 1'b0, 8'h3C, 3'd0, 8'hCC, 1'b1, 1};
    vecs[7]  = '{8'h05, 1'b0, 4'b0100, 1'b1, 8'h03, 3'd0, 8'h02, 1'b1, 1};
    vecs[8]  = '{8'h01, 1'b1, 4'b1001, 1'b0, 8'h00, 3'd0, 8'h03, 1'b0, 1};
    vecs[9]  = '{8'h01, 1'b0, 4'b1100, 1'b0, 8'h00, 3'd0, 8'h00, 1'b1, 1};
    vecs[10] = '{8'hA5, 1'b0, 4'b1000, 1'b0, 8'h00, 3'd7, 8'h00, 1'b1, 8};
    vecs[11] = '{8'h81, 1'b0, 4'b1101, 1'b0, 8'h00, 3'd1, 8'hA0, 1'b0, 2};
    vecs[12] = '{8'h0F, 1'b0, 4'b0001, 1'b0, 8'hF0, 3'd5, 8'hFF, 1'b0, 1};
    rot_seq[0] = 8'h81; rot_seq[1] = 8'h03; rot_seq[2] = 8'h06; rot_seq[3] = 8'h0C;

    // Reset with a command offered: nothing may be accepted.
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 4'b0100; cmd_xy = 1'b0; cmd_b = 8'h01;
    cmd_cnt = '0; acc_we = 1'b0; acc_wdata = '0; carry_we = 1'b0; carry_wdata = 1'b0;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0; rst_n = 1'b1;
    chk("rst_acc", acc, 8'h00);
    chk("rst_carry", carry, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rst_zero", zero, 1'b0);
`endif
    @(negedge clk);
    chk("rst_no_accept", busy, 1'b0);

    // Direct loads block the command port.
    acc_we = 1'b1; acc_wdata = 8'h00;
    #1 chk("ready_during_load", cmd_ready, 1'b0);
    @(negedge clk);
    acc_we = 1'b0;

    for (int i = 0; i < 13; i++) begin
      load(vecs[i].a0, vecs[i].c0);
      issue(vecs[i].op, vecs[i].xy, vecs[i].b, vecs[i].cnt);
      wait_done(iters);
      chk($sformatf("v%0d_iters", i), iters, vecs[i].exp_iter);
      chk($sformatf("v%0d_done", i), done, 1'b1);
      chk($sformatf("v%0d_acc", i), acc, vecs[i].exp_acc);
      chk($sformatf("v%0d_carry", i), carry, vecs[i].exp_c);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      chk($sformatf("v%0d_zero", i), zero, (vecs[i].exp_acc == 0));
`endif
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
    end

    // Back-to-back: second command issued in the done cycle.
    load(8'hFF, 1'b0);
    issue(4'b0100, 1'b0, 8'h01, 3'd0);
    wait_done(iters);
    chk("b2b_first_done", done, 1'b1);
    chk("b2b_first_acc", acc, 8'h00);
    chk("b2b_first_carry", carry, 1'b1);
    issue(4'b0101, 1'b0, 8'h00, 3'd0);
    chk("b2b_second_busy", busy, 1'b1);
    wait_done(iters);
    chk("b2b_second_done", done, 1'b1);
    chk("b2b_second_acc", acc, 8'h01);
    chk("b2b_second_carry", carry, 1'b0);
    @(negedge clk);

    // Rotate left by 4: ALU a operand walks through each intermediate value.
    load(8'h81, 1'b0);
    issue(4'b1011, 1'b0, 8'h00, 3'd3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rot_alu_a%0d", i), alu_a, rot_seq[i]);
      chk($sformatf("rot_busy%0d", i), busy, 1'b1);
      @(negedge clk);
    end
    chk("rot_done", done, 1'b1);
    chk("rot_acc", acc, 8'h18);
    chk("rot_carry", carry, 1'b0);
    @(negedge clk);

    // cmd_valid held through an 8-iteration shift is not taken until done.
    load(8'h80, 1'b0);
    cmd_valid = 1'b1; cmd_op = 4'b1111; cmd_xy = 1'b0; cmd_b = 8'h00; cmd_cnt = 3'd7;
    @(negedge clk);
    cmd_op = 4'b0100; cmd_b = 8'h01; cmd_cnt = 3'd0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("hold_busy%0d", i), busy, 1'b1);
      chk($sformatf("hold_ready%0d", i), cmd_ready, 1'b0);
      @(negedge clk);
    end
    chk("hold_done", done, 1'b1);
    chk("hold_acc", acc, 8'hFF);
    chk("hold_carry", carry, 1'b1);
    chk("hold_ready_at_done", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_next_busy", busy, 1'b1);
    @(negedge clk);
    chk("hold_next_done", done, 1'b1);
    chk("hold_next_acc", acc, 8'h00);
    chk("hold_next_carry", carry, 1'b1);
    @(negedge clk);

    // Reset in the third EXEC cycle aborts without a done pulse.
    load(8'h80, 1'b0);
    issue(4'b1111, 1'b0, 8'h00, 3'd7);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_acc", acc, 8'h00);
    chk("abort_carry", carry, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("abort_zero", zero, 1'b0);
`endif
    @(negedge clk);
    chk("abort_no_done", done, 1'b0);
    chk("abort_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequencer on the driving side of the 8-bit ALU interface (a, b, op[3:0], xy, cin -> q, cout).
- Owns the accumulator and carry flag, and issues accepted commands to the external ALU.
- Writes back q/cout each cycle. Repeats shift-class ops for multi-bit shifts.
- Sits between instruction decode (command handshake) and the combinational ALU.

Parameters:
- W, 8, datapath width; must match ALU width.
- CNT_W, 3, shift-count field width; a shift runs cnt+1 iterations, so 1..8.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when valid&ready
- cmd_op  input  4  ALU op code
- cmd_xy  input  1  ALU xy modifier
- cmd_b  input  W  operand B
- cmd_cnt  input  CNT_W  shift count minus one; ignored for op[3]=0
- acc_we  input  1  direct accumulator load, IDLE only
- acc_wdata  input  W  load data
- carry_we  input  1  direct carry load, IDLE only
- carry_wdata  input  1  carry load value
- alu_a  output  W  to ALU a (= acc)
- alu_b  output  W  to ALU b (= latched B)
- alu_op  output  4  to ALU op (= latched op)
- alu_xy  output  1  to ALU xy (= latched xy)
- alu_cin  output  1  to ALU cin (= carry flag)
- alu_q  input  W  from ALU q
- alu_cout  input  1  from ALU cout
- acc  output  W  accumulator
- carry  output  1  carry flag
- busy  output  1  high in EXEC
- done  output  1  one-cycle pulse after final write-back

Behaviour:
- Reset, sampled on clk when rst_n=0:
  - acc=0, carry=0, op/xy/B/count registers=0.
  - state=IDLE, done=0, busy=0.
  - Reset overrides everything, including mid-EXEC. No done pulse follows an aborted op.
- States: IDLE, EXEC.
- IDLE:
  - cmd_ready = !acc_we && !carry_we.
  - If acc_we: acc<=acc_wdata. If carry_we: carry<=carry_wdata. Both may occur in the same cycle.
  - On valid&ready: latch op, xy, B. Set remaining = (op[3] ? cmd_cnt : 0). Go to EXEC.
- EXEC:
  - busy=1, cmd_ready=0. acc_we and carry_we are ignored.
  - Every cycle: acc<=alu_q, carry<=alu_cout.
  - If remaining==0: go to IDLE and set done=1 for the next cycle. Else remaining-1.
- ALU outputs are driven combinationally from registers in all states. The ALU is purely combinational, so write-back lands at the end of the same cycle.
- Latency:
  - Accept at edge N. Iterations occupy cycles N+1..N+k.
  - done is high during cycle N+k+1, where k=1 for non-shift ops and cnt+1 for shifts.
  - A new command may be accepted in the cycle done is high (back-to-back, no bubble beyond done).
- Op classes by op[3:2]:
  - 00 bitwise; 01 add/sub; 10 shift left; 11 shift right.
  - Shift-in bit for 10/11 is set by op[1:0]: 00 zero, 01 carry, 10 a[0], 11 a[7].
  - The sequencer does not interpret op beyond op[3]; the ALU defines semantics.
- Each shift iteration feeds the previous iteration's acc and carry.
- Count wrap: cnt at max gives 2^CNT_W iterations; remaining never underflows.
- cmd_valid may drop without acceptance; there is no obligation to hold.

Optional Feature:
- Macro: ALU_SEQ_ZERO_FLAG_EN.
- Defined:
  - Adds output zero (1 bit), reset 0.
  - Updated on every EXEC write-back to (alu_q==0). Also updated on acc_we to (acc_wdata==0).
- Undefined: no zero port and no zero logic.

Test Plan:
- Reset -> acc=0x00, carry=0, cmd_ready=1, busy=0, done=0. Reset asserted while cmd_valid=1 -> nothing accepted.
- acc_we 0x7F, then cmd op=0100 b=0x01 accepted at edge N -> busy in cycle N+1, done in N+2, acc=0x80, carry=0.
- acc=0xFF, op=0100 b=0x01 -> acc=0x00, carry=1. Back-to-back in the done cycle: op=0101 b=0x00 -> acc=0x01, carry=0.
- acc=0x81, op=1011 (rotate left) cnt=3 -> alu_a sequence 0x81,0x03,0x06,0x0C. Final acc=0x18, carry=0; done 5 cycles after accept edge.
- acc=0x80, op=1111 (arith right) cnt=7 -> 8 iterations, acc=0xFF, carry=1. cmd_valid held high during EXEC is not accepted until done.
- Start op=1111 cnt=7 then rst_n=0 in third EXEC cycle -> next cycle acc=0, carry=0, IDLE, no done pulse. With ALU_SEQ_ZERO_FLAG_EN, also zero=0.
